// File: rtl/booth_pkg.sv
// Shared definitions for the sequential Booth multiplier: controller state
// encoding and the sizing rule for the step counter.
package booth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The counter must hold WIDTH+1, the number of Booth steps.
    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/booth_addsub.sv
// E-bit combinational adder/subtractor for the Booth accumulator.
// Subtraction is formed as a + ~m + 1 and wraps modulo 2^E.
module booth_addsub #(
    parameter int E = 9
) (
    input  logic [E-1:0] a,
    input  logic [E-1:0] m,
    input  logic         sub,
    output logic [E-1:0] result
);

    logic [E-1:0] m_sel;
    logic [E-1:0] carry_in;

    assign m_sel    = sub ? ~m : m;
    assign carry_in = {{(E-1){1'b0}}, sub};
    assign result   = a + m_sel + carry_in;

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with start/done handshake. Operands are
// widened by one bit so signed and unsigned products share one datapath.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int E  = WIDTH + 1;
    localparam int CW = cnt_width(WIDTH);

    state_t               state_reg;
    logic [E-1:0]         a_reg;
    logic [E-1:0]         q_reg;
    logic                 q1_reg;
    logic [E-1:0]         m_reg;
    logic [CW-1:0]        count_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic [2*WIDTH-1:0]   product_reg;

    logic [E-1:0]         m_ext;
    logic [E-1:0]         q_ext;
    logic                 do_op;
    logic                 do_sub;
    logic [E-1:0]         sum;
    logic [E-1:0]         a_next;
    logic [E-1:0]         a_shift;
    logic [E-1:0]         q_shift;

    // The extension bit is the sign in signed mode and zero otherwise.
    assign m_ext = {signed_mode & multiplicand[WIDTH-1], multiplicand};
    assign q_ext = {signed_mode & multiplier[WIDTH-1], multiplier};

    assign do_op  = q_reg[0] ^ q1_reg;
    assign do_sub = q_reg[0] & ~q1_reg;

    booth_addsub #(.E(E)) u_addsub (
        .a      (a_reg),
        .m      (m_reg),
        .sub    (do_sub),
        .result (sum)
    );

    assign a_next  = do_op ? sum : a_reg;
    assign a_shift = {a_next[E-1], a_next[E-1:1]};
    assign q_shift = {a_next[0], q_reg[E-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            a_reg       <= '0;
            q_reg       <= '0;
            q1_reg      <= 1'b0;
            m_reg       <= '0;
            count_reg   <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            product_reg <= '0;
        end else begin
            // busy and done trail the state by one cycle so they stay registered.
            busy_reg <= (state_reg == ST_CALC);
            done_reg <= (state_reg == ST_DONE);
            unique case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        m_reg     <= m_ext;
                        q_reg     <= q_ext;
                        a_reg     <= '0;
                        q1_reg    <= 1'b0;
                        count_reg <= CW'(E);
                        state_reg <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    a_reg     <= a_shift;
                    q_reg     <= q_shift;
                    q1_reg    <= q_reg[0];
                    count_reg <= count_reg - CW'(1);
                    if (count_reg == CW'(1)) begin
                        product_reg <= {a_shift[WIDTH-1:0], q_shift};
                        state_reg   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign product = product_reg;

endmodule
